// File: rtl/echo_avg_pkg.sv
// Shared definitions for the echo averager: sample width, clock-derived width limits
// and the per-cycle sample classification used by the control path.
package echo_avg_pkg;

    localparam int          ECHO_LENGTH    = 32;
    localparam int unsigned CLK_FREQ_MHZ   = 100;
    localparam int          DEF_LOG2_DEPTH = 3;

    function automatic logic [ECHO_LENGTH-1:0] us_to_cycles(input int unsigned us);
        return ECHO_LENGTH'(us * CLK_FREQ_MHZ);
    endfunction

    // 1 us glitch floor and 38 ms no-echo timeout of the ranging sensor
    localparam logic [ECHO_LENGTH-1:0] DEF_MIN_WIDTH = us_to_cycles(1);
    localparam logic [ECHO_LENGTH-1:0] DEF_MAX_WIDTH = us_to_cycles(38000);

    typedef enum logic [1:0] {
        SMP_IDLE,
        SMP_ACCEPT,
        SMP_REJECT,
        SMP_FLUSH
    } smp_kind_e;

endpackage

// File: rtl/echo_avg_buf.sv
// Circular sample store for the averager: synchronous write, combinational read
// at the same address so the evicted sample is visible before it is overwritten.
module echo_avg_buf
    import echo_avg_pkg::*;
#(
    parameter int LENGTH     = ECHO_LENGTH,
    parameter int LOG2_DEPTH = DEF_LOG2_DEPTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [LOG2_DEPTH-1:0] addr,
    input  logic [LENGTH-1:0]     wdata,
    output logic [LENGTH-1:0]     rdata
);

    localparam int DEPTH = 1 << LOG2_DEPTH;

    logic [LENGTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/echo_avg.sv
// Sliding-window mean of in-range echo pulse widths; emits a one-cycle avg_rdy
// strobe with the truncated mean once the window is full.
module echo_avg
    import echo_avg_pkg::*;
#(
    parameter int                LENGTH     = ECHO_LENGTH,
    parameter int                LOG2_DEPTH = DEF_LOG2_DEPTH,
    parameter logic [LENGTH-1:0] MIN_WIDTH  = LENGTH'(DEF_MIN_WIDTH),
    parameter logic [LENGTH-1:0] MAX_WIDTH  = LENGTH'(DEF_MAX_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_rdy,
    input  logic [LENGTH-1:0]     in_width,
    input  logic                  flush,
    output logic                  avg_rdy,
    output logic [LENGTH-1:0]     avg_out,
    output logic                  reject,
    output logic                  full,
    output logic [LOG2_DEPTH:0]   count
);

    localparam int                DEPTH    = 1 << LOG2_DEPTH;
    localparam int                SUM_W    = LENGTH + LOG2_DEPTH;
    localparam logic [LOG2_DEPTH:0] CNT_LAST = (LOG2_DEPTH+1)'(DEPTH - 1);

    logic [LOG2_DEPTH-1:0] wr_ptr_reg;
    logic [SUM_W-1:0]      sum_reg;
    logic [SUM_W-1:0]      sum_next;
    logic [LOG2_DEPTH:0]   count_reg;
    logic                  full_reg;
    logic                  avg_rdy_reg;
    logic                  reject_reg;
    logic [LENGTH-1:0]     avg_reg;
    logic [LENGTH-1:0]     evict_data;
    logic                  full_next;
    logic                  in_range;
    smp_kind_e             kind;

    echo_avg_buf #(
        .LENGTH     (LENGTH),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) u_buf (
        .clk   (clk),
        .we    (kind == SMP_ACCEPT),
        .addr  (wr_ptr_reg),
        .wdata (in_width),
        .rdata (evict_data)
    );

    assign in_range = (in_width >= MIN_WIDTH) && (in_width <= MAX_WIDTH);

    // flush outranks a simultaneous sample, which is dropped silently
    always_comb begin
        kind = SMP_IDLE;
        if (flush) begin
            kind = SMP_FLUSH;
        end else if (in_rdy) begin
            kind = in_range ? SMP_ACCEPT : SMP_REJECT;
        end
    end

    // The extra LOG2_DEPTH bits hold DEPTH full-scale samples, so no overflow
    always_comb begin
        sum_next = sum_reg + {{LOG2_DEPTH{1'b0}}, in_width};
        if (full_reg) begin
            sum_next = sum_next - {{LOG2_DEPTH{1'b0}}, evict_data};
        end
    end

    assign full_next = full_reg || (count_reg == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg  <= '0;
            sum_reg     <= '0;
            count_reg   <= '0;
            full_reg    <= 1'b0;
            avg_rdy_reg <= 1'b0;
            reject_reg  <= 1'b0;
            avg_reg     <= '0;
        end else begin
            avg_rdy_reg <= 1'b0;
            reject_reg  <= 1'b0;
            case (kind)
                SMP_FLUSH: begin
                    wr_ptr_reg <= '0;
                    sum_reg    <= '0;
                    count_reg  <= '0;
                    full_reg   <= 1'b0;
                end
                SMP_ACCEPT: begin
                    wr_ptr_reg <= wr_ptr_reg + LOG2_DEPTH'(1);
                    sum_reg    <= sum_next;
                    full_reg   <= full_next;
                    if (!full_reg) begin
                        count_reg <= count_reg + (LOG2_DEPTH+1)'(1);
                    end
                    if (full_next) begin
                        avg_rdy_reg <= 1'b1;
                        avg_reg     <= sum_next[SUM_W-1:LOG2_DEPTH];
                    end
                end
                SMP_REJECT: begin
                    reject_reg <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign avg_rdy = avg_rdy_reg;
    assign avg_out = avg_reg;
    assign reject  = reject_reg;
    assign full    = full_reg;
    assign count   = count_reg;

endmodule

// File: tb/tb_echo_avg.sv
// Directed bench for echo_avg (depth 4, widths 100..1000): a reference window model
// pushes expected outputs to a scoreboard that is popped one cycle after each step.
module tb_echo_avg;

    localparam int LENGTH = 32;
    localparam int LOG2_D = 2;
    localparam int DEPTH  = 4;
    localparam int MIN_W  = 100;
    localparam int MAX_W  = 1000;

    typedef struct {
        logic        rdy;
        logic [31:0] avg;
        logic        rej;
        logic [31:0] cnt;
        logic        full;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_rdy = 1'b0;
    logic [LENGTH-1:0] in_width = '0;
    logic              flush = 1'b0;
    logic              avg_rdy;
    logic [LENGTH-1:0] avg_out;
    logic              reject;
    logic              full;
    logic [LOG2_D:0]   count;

    int checks = 0;
    int errors = 0;

    int   win[$];
    int   m_avg = 0;
    exp_t sb[$];

    echo_avg #(
        .LENGTH     (LENGTH),
        .LOG2_DEPTH (LOG2_D),
        .MIN_WIDTH  (32'd100),
        .MAX_WIDTH  (32'd1000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_rdy   (in_rdy),
        .in_width (in_width),
        .flush    (flush),
        .avg_rdy  (avg_rdy),
        .avg_out  (avg_out),
        .reject   (reject),
        .full     (full),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, predict the result, then compare one cycle later
    task automatic step(input logic r, input logic v, input int w, input logic f);
        exp_t e;
        longint s;
        rst      = r;
        in_rdy   = v;
        in_width = w;
        flush    = f;
        e.rdy = 1'b0;
        e.rej = 1'b0;
        if (r) begin
            win.delete();
            m_avg = 0;
        end else if (f) begin
            win.delete();
        end else if (v && w >= MIN_W && w <= MAX_W) begin
            if (win.size() == DEPTH) void'(win.pop_front());
            win.push_back(w);
            if (win.size() == DEPTH) begin
                s = 0;
                foreach (win[k]) s += win[k];
                m_avg = int'(s / DEPTH);
                e.rdy = 1'b1;
            end
        end else if (v) begin
            e.rej = 1'b1;
        end
        e.avg  = m_avg;
        e.cnt  = win.size();
        e.full = (win.size() == DEPTH);
        sb.push_back(e);

        @(posedge clk);
        #1;
        rst    = 1'b0;
        in_rdy = 1'b0;
        flush  = 1'b0;

        e = sb.pop_front();
        $display("step rst=%0d rdy=%0d w=%0d flush=%0d -> avg_rdy=%0d avg_out=%0d reject=%0d count=%0d full=%0d",
                 r, v, w, f, avg_rdy, avg_out, reject, count, full);
        check("avg_rdy", 32'(avg_rdy), 32'(e.rdy));
        check("avg_out", avg_out, e.avg);
        check("reject",  32'(reject),  32'(e.rej));
        check("count",   32'(count),   e.cnt);
        check("full",    32'(full),    32'(e.full));
    endtask

    initial begin
        // reset state
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);

        // fill
        step(0, 1, 200, 0);
        step(0, 1, 400, 0);
        step(0, 1, 600, 0);
        step(0, 1, 800, 0);
        step(0, 0, 0, 0);

        // slide
        step(0, 1, 1000, 0);
        step(0, 1, 101, 0);
        step(0, 0, 0, 0);

        // range edges
        step(0, 1, 99, 0);
        step(0, 1, 1001, 0);
        step(0, 1, 100, 0);
        step(0, 1, 1000, 0);
        step(0, 1, 0, 0);
        step(0, 1, 32'hFFFF_FFFF, 0);

        // back-to-back accepts
        step(0, 1, 500, 0);
        step(0, 1, 600, 0);
        step(0, 1, 700, 0);
        step(0, 1, 900, 0);
        step(0, 0, 0, 0);

        // flush mid-window alongside a sample, then refill
        step(0, 1, 300, 1);
        step(0, 1, 300, 0);
        step(0, 1, 300, 0);
        step(0, 1, 300, 0);
        step(0, 1, 300, 0);
        step(0, 0, 0, 0);

        // flush with an out-of-range sample: no reject strobe
        step(0, 1, 5, 1);
        step(0, 1, 200, 0);
        step(0, 1, 400, 0);
        step(0, 1, 600, 0);
        step(0, 1, 800, 0);

        // reset with a full window and a concurrent sample, then refill
        step(1, 1, 500, 1);
        step(0, 1, 200, 0);
        step(0, 1, 400, 0);
        step(0, 1, 600, 0);
        step(0, 1, 800, 0);
        step(0, 1, 1000, 0);
        step(0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
